// File: rtl/vga_pattern_gen.sv
// VGA timing and test-pattern generator: programmable pixel-clock divider,
// sync/blanking decode and four selectable patterns, all outputs registered.
module vga_pattern_gen #(
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int H_ACTIVE   = 640,
  parameter int H_FRONT    = 16,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 10,
  parameter int CLK_DIV    = 2,
  parameter bit SYNC_POL   = 1'b0,
  parameter int R_W        = 5,
  parameter int G_W        = 6,
  parameter int B_W        = 5,
  parameter int GRAD_SHIFT = 4,
  parameter int CHK_LOG2   = 5
) (
  input  logic                              sys_clk,
  input  logic                              sys_rst_n,
  input  logic                              en,
  input  logic [1:0]                        mode,
  input  logic [R_W+G_W+B_W-1:0]            solid_rgb,
  output logic                              hsync,
  output logic                              vsync,
  output logic                              de,
  output logic [$clog2(H_ACTIVE)-1:0]       pix_x,
  output logic [$clog2(V_ACTIVE)-1:0]       pix_y,
  output logic [R_W+G_W+B_W-1:0]            rgb,
  output logic                              frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int H_ACT_S = H_SYNC + H_BACK;
  localparam int H_ACT_E = H_ACT_S + H_ACTIVE;
  localparam int V_ACT_S = V_SYNC + V_BACK;
  localparam int V_ACT_E = V_ACT_S + V_ACTIVE;
  localparam int HC_W    = $clog2(H_TOTAL);
  localparam int VC_W    = $clog2(V_TOTAL);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int X_W     = $clog2(H_ACTIVE);
  localparam int Y_W     = $clog2(V_ACTIVE);
  localparam int RGB_W   = R_W + G_W + B_W;
  localparam int BAR_W   = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;

  // Bar index bits map directly onto channel enables: white..black.
  function automatic logic [RGB_W-1:0] bar_colour(input logic [2:0] idx);
    bar_colour = {{R_W{~idx[1]}}, {G_W{~idx[2]}}, {B_W{~idx[0]}}};
  endfunction

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [HC_W-1:0]  h_cnt_q, h_cnt_d;
  logic [VC_W-1:0]  v_cnt_q, v_cnt_d;
  logic [1:0]       mode_q;
  logic [RGB_W-1:0] solid_q;
  logic             pix_en_s;

  logic [31:0]      h_ext_s, v_ext_s, bar_div_s;
  logic             h_act_s, v_act_s, de_s, frame_s, chk_s, hs_s, vs_s;
  logic [X_W-1:0]   px_s;
  logic [Y_W-1:0]   py_s;
  logic [1:0]       mode_s;
  logic [RGB_W-1:0] solid_s, grad_s, pat_s, rgb_s;
  logic [2:0]       bar_idx_s;

  // Pixel-tick divider and raster counters; en=0 parks everything at (0,0).
  always_comb begin
    div_cnt_d = div_cnt_q;
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    pix_en_s  = 1'b0;
    if (!en) begin
      div_cnt_d = {DIV_W{1'b0}};
      h_cnt_d   = {HC_W{1'b0}};
      v_cnt_d   = {VC_W{1'b0}};
    end else begin
      pix_en_s = (div_cnt_q == DIV_W'(CLK_DIV - 1));
      if (pix_en_s) begin
        div_cnt_d = {DIV_W{1'b0}};
        if (h_cnt_q == HC_W'(H_TOTAL - 1)) begin
          h_cnt_d = {HC_W{1'b0}};
          if (v_cnt_q == VC_W'(V_TOTAL - 1)) begin
            v_cnt_d = {VC_W{1'b0}};
          end else begin
            v_cnt_d = v_cnt_q + VC_W'(1);
          end
        end else begin
          h_cnt_d = h_cnt_q + HC_W'(1);
        end
      end else begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
      end
    end
  end

  // Decode sync, blanking, coordinates and pattern from the current counters.
  always_comb begin
    h_ext_s = 32'(h_cnt_q);
    v_ext_s = 32'(v_cnt_q);
    h_act_s = (h_ext_s >= 32'(H_ACT_S)) && (h_ext_s < 32'(H_ACT_E));
    v_act_s = (v_ext_s >= 32'(V_ACT_S)) && (v_ext_s < 32'(V_ACT_E));
    de_s    = h_act_s && v_act_s;
    hs_s    = (h_ext_s < 32'(H_SYNC)) ? SYNC_POL : ~SYNC_POL;
    vs_s    = (v_ext_s < 32'(V_SYNC)) ? SYNC_POL : ~SYNC_POL;
    if (de_s) begin
      px_s = X_W'(h_ext_s - 32'(H_ACT_S));
      py_s = Y_W'(v_ext_s - 32'(V_ACT_S));
    end else begin
      px_s = {X_W{1'b0}};
      py_s = {Y_W{1'b0}};
    end
    frame_s = (h_cnt_q == {HC_W{1'b0}}) && (v_cnt_q == {VC_W{1'b0}});
    // The frame's first tick already uses the newly latched selection.
    if (frame_s) begin
      mode_s  = mode;
      solid_s = solid_rgb;
    end else begin
      mode_s  = mode_q;
      solid_s = solid_q;
    end
    bar_div_s = 32'(px_s) / 32'(BAR_W);
    bar_idx_s = (bar_div_s > 32'd7) ? 3'd7 : bar_div_s[2:0];
    grad_s    = {R_W'(px_s >> GRAD_SHIFT), G_W'(px_s >> GRAD_SHIFT), B_W'(px_s >> GRAD_SHIFT)};
    chk_s     = 1'(px_s >> CHK_LOG2) ^ 1'(py_s >> CHK_LOG2);
    case (mode_s)
      2'd0:    pat_s = bar_colour(bar_idx_s);
      2'd1:    pat_s = grad_s;
      2'd2:    pat_s = chk_s ? {RGB_W{1'b1}} : {RGB_W{1'b0}};
      2'd3:    pat_s = solid_s;
      default: pat_s = {RGB_W{1'b0}};
    endcase
    if (de_s) begin
      rgb_s = pat_s;
    end else begin
      rgb_s = {RGB_W{1'b0}};
    end
  end

  // Counter state.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_cnt_q <= {DIV_W{1'b0}};
      h_cnt_q   <= {HC_W{1'b0}};
      v_cnt_q   <= {VC_W{1'b0}};
    end else begin
      div_cnt_q <= div_cnt_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
    end
  end

  // Pattern selection, refreshed only on a frame's first tick.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mode_q  <= 2'd0;
      solid_q <= {RGB_W{1'b0}};
    end else if (pix_en_s && frame_s) begin
      mode_q  <= mode;
      solid_q <= solid_rgb;
    end
  end

  // Output registers: load on each tick, idle values while disabled.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      de          <= 1'b0;
      pix_x       <= {X_W{1'b0}};
      pix_y       <= {Y_W{1'b0}};
      rgb         <= {RGB_W{1'b0}};
      frame_start <= 1'b0;
    end else if (!en) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      de          <= 1'b0;
      pix_x       <= {X_W{1'b0}};
      pix_y       <= {Y_W{1'b0}};
      rgb         <= {RGB_W{1'b0}};
      frame_start <= 1'b0;
    end else if (pix_en_s) begin
      hsync       <= hs_s;
      vsync       <= vs_s;
      de          <= de_s;
      pix_x       <= px_s;
      pix_y       <= py_s;
      rgb         <= rgb_s;
      frame_start <= frame_s;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: small 28x14 raster, CLK_DIV=2 main
// instance plus a CLK_DIV=1 instance for the asynchronous-reset sequence.
module tb_vga_pattern_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, rst1_n, en1;
  logic [1:0]  mode, mode1;
  logic [15:0] solid, solid1;
  logic        hs, vs, de, fs, hs1, vs1, de1, fs1;
  logic [3:0]  px, px1;
  logic [2:0]  py, py1;
  logic [15:0] rgb, rgb1;

  vga_pattern_gen #(
    .H_SYNC(4), .H_BACK(4), .H_ACTIVE(16), .H_FRONT(4),
    .V_SYNC(2), .V_BACK(2), .V_ACTIVE(8), .V_FRONT(2),
    .CLK_DIV(2), .SYNC_POL(1'b0), .R_W(5), .G_W(6), .B_W(5),
    .GRAD_SHIFT(1), .CHK_LOG2(1)
  ) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .en(en), .mode(mode), .solid_rgb(solid),
    .hsync(hs), .vsync(vs), .de(de), .pix_x(px), .pix_y(py), .rgb(rgb),
    .frame_start(fs)
  );

  vga_pattern_gen #(
    .H_SYNC(4), .H_BACK(4), .H_ACTIVE(16), .H_FRONT(4),
    .V_SYNC(2), .V_BACK(2), .V_ACTIVE(8), .V_FRONT(2),
    .CLK_DIV(1), .SYNC_POL(1'b0), .R_W(5), .G_W(6), .B_W(5),
    .GRAD_SHIFT(1), .CHK_LOG2(1)
  ) dut1 (
    .sys_clk(clk), .sys_rst_n(rst1_n), .en(en1), .mode(mode1), .solid_rgb(solid1),
    .hsync(hs1), .vsync(vs1), .de(de1), .pix_x(px1), .pix_y(py1), .rgb(rgb1),
    .frame_start(fs1)
  );

  // Clock edges seen with enable high since the last restart of each instance.
  int n, n1;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) n <= 0; else if (en) n <= n + 1; else n <= 0;
  always @(posedge clk or negedge rst1_n)
    if (!rst1_n) n1 <= 0; else if (en1) n1 <= n1 + 1; else n1 <= 0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cnt(input bit which, input int target);
    int guard;
    int cur;
    guard = 0;
    cur = which ? n1 : n;
    while (cur < target && guard < 5000) begin
      @(negedge clk);
      guard++;
      cur = which ? n1 : n;
    end
    if (cur != target) begin
      checks++;
      errors++;
      $display("FAIL wait_cnt: got %0d expected %0d", cur, target);
    end
  endtask

  typedef struct {
    int          f;
    int          h;
    int          v;
    logic [1:0]  mode_in;
    logic [15:0] solid_in;
    logic        exp_de;
    logic [15:0] exp_rgb;
  } vec_t;

  vec_t vecs[27];

  initial begin
    int t, h, v, tick;
    int hs_err, vs_err, de_err, px_err, py_err, blank_err, fs_err, de_cnt;
    logic e_de;

    // frame 0: colour bars (mode 1 requested for next frame)
    vecs[0]  = '{0,  8,  4, 2'd1, 16'h0000, 1'b1, 16'hFFFF};
    vecs[1]  = '{0,  9,  4, 2'd1, 16'h0000, 1'b1, 16'hFFFF};
    vecs[2]  = '{0, 10,  4, 2'd1, 16'h0000, 1'b1, 16'hFFE0};
    vecs[3]  = '{0, 13,  4, 2'd1, 16'h0000, 1'b1, 16'h07FF};
    vecs[4]  = '{0, 14,  4, 2'd1, 16'h0000, 1'b1, 16'h07E0};
    vecs[5]  = '{0, 17,  4, 2'd1, 16'h0000, 1'b1, 16'hF81F};
    vecs[6]  = '{0, 18,  4, 2'd1, 16'h0000, 1'b1, 16'hF800};
    vecs[7]  = '{0, 21,  4, 2'd1, 16'h0000, 1'b1, 16'h001F};
    vecs[8]  = '{0, 22,  4, 2'd1, 16'h0000, 1'b1, 16'h0000};
    vecs[9]  = '{0, 23,  4, 2'd1, 16'h0000, 1'b1, 16'h0000};
    vecs[10] = '{0, 24,  4, 2'd1, 16'h0000, 1'b0, 16'h0000};
    vecs[11] = '{0, 12, 11, 2'd1, 16'h0000, 1'b1, 16'h07FF};
    // frame 1: gradient with shift 1
    vecs[12] = '{1,  8,  4, 2'd2, 16'h0000, 1'b1, 16'h0000};
    vecs[13] = '{1, 13,  5, 2'd2, 16'h0000, 1'b1, 16'h1042};
    vecs[14] = '{1, 23,  6, 2'd2, 16'h0000, 1'b1, 16'h38E7};
    // frame 2: checkerboard; solid requested mid-frame must not show yet
    vecs[15] = '{2,  8,  4, 2'd3, 16'h1234, 1'b1, 16'h0000};
    vecs[16] = '{2, 10,  4, 2'd3, 16'h1234, 1'b1, 16'hFFFF};
    vecs[17] = '{2, 11,  5, 2'd3, 16'h1234, 1'b1, 16'hFFFF};
    vecs[18] = '{2,  8,  6, 2'd3, 16'h1234, 1'b1, 16'hFFFF};
    vecs[19] = '{2, 10,  6, 2'd3, 16'h1234, 1'b1, 16'h0000};
    vecs[20] = '{2, 11,  9, 2'd3, 16'h1234, 1'b1, 16'hFFFF};
    vecs[21] = '{2, 15, 11, 2'd3, 16'h1234, 1'b1, 16'h0000};
    // frame 3: solid colour
    vecs[22] = '{3,  7,  4, 2'd3, 16'h1234, 1'b0, 16'h0000};
    vecs[23] = '{3,  8,  4, 2'd3, 16'h1234, 1'b1, 16'h1234};
    vecs[24] = '{3, 17,  7, 2'd3, 16'h1234, 1'b1, 16'h1234};
    vecs[25] = '{3, 23, 11, 2'd3, 16'h1234, 1'b1, 16'h1234};
    vecs[26] = '{3, 12, 13, 2'd3, 16'h1234, 1'b0, 16'h0000};

    rst_n = 1'b0; en = 1'b1; mode = 2'd0; solid = 16'h0000;
    rst1_n = 1'b0; en1 = 1'b1; mode1 = 2'd3; solid1 = 16'hABCD;
    repeat (3) @(negedge clk);
    chk("rst_hsync", hs, 1); chk("rst_vsync", vs, 1); chk("rst_de", de, 0);
    chk("rst_rgb", rgb, 0);  chk("rst_pix_x", px, 0); chk("rst_fs", fs, 0);

    // Raster sweep over the first frame, sampling both clocks of every tick.
    rst_n = 1'b1;
    wait_cnt(1'b0, 1);
    chk("pre_tick_fs", fs, 0);
    chk("pre_tick_hsync", hs, 1);
    hs_err = 0; vs_err = 0; de_err = 0; px_err = 0; py_err = 0;
    blank_err = 0; fs_err = 0; de_cnt = 0;
    for (int k = 2; k <= 785; k++) begin
      wait_cnt(1'b0, k);
      tick = (k - 2) / 2;
      h = tick % 28;
      v = tick / 28;
      e_de = (h >= 8) && (h < 24) && (v >= 4) && (v < 12);
      if (hs !== (h >= 4)) hs_err++;
      if (vs !== (v >= 2)) vs_err++;
      if (de !== e_de) de_err++;
      if (32'(px) !== (e_de ? h - 8 : 0)) px_err++;
      if (32'(py) !== (e_de ? v - 4 : 0)) py_err++;
      if (!de && rgb !== 16'h0000) blank_err++;
      if (fs !== (tick == 0)) fs_err++;
      if (de && (k % 2 == 0)) de_cnt++;
    end
    chk("sweep_hsync", hs_err, 0);
    chk("sweep_vsync", vs_err, 0);
    chk("sweep_de", de_err, 0);
    chk("sweep_pix_x", px_err, 0);
    chk("sweep_pix_y", py_err, 0);
    chk("sweep_blank_rgb", blank_err, 0);
    chk("sweep_frame_start", fs_err, 0);
    chk("sweep_de_ticks", de_cnt, 128);

    // Pattern vectors from a fresh restart.
    @(negedge clk);
    rst_n = 1'b0; mode = 2'd0; solid = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 27; i++) begin
      t = vecs[i].f * 392 + vecs[i].v * 28 + vecs[i].h;
      wait_cnt(1'b0, 2 * t + 2);
      chk($sformatf("vec%0d_de", i), de, vecs[i].exp_de);
      chk($sformatf("vec%0d_rgb", i), rgb, vecs[i].exp_rgb);
      chk($sformatf("vec%0d_pix_x", i), px, vecs[i].exp_de ? vecs[i].h - 8 : 0);
      chk($sformatf("vec%0d_pix_y", i), py, vecs[i].exp_de ? vecs[i].v - 4 : 0);
      wait_cnt(1'b0, 2 * t + 3);
      chk($sformatf("vec%0d_rgb_hold", i), rgb, vecs[i].exp_rgb);
      mode = vecs[i].mode_in;
      solid = vecs[i].solid_in;
    end

    // Drop enable while h_cnt=20 on an active line, then re-enable.
    t = 4 * 392 + 5 * 28 + 20;
    wait_cnt(1'b0, 2 * t + 1);
    chk("en_pre_de", de, 1);
    chk("en_pre_rgb", rgb, 16'h1234);
    en = 1'b0;
    @(negedge clk);
    chk("en_off_de", de, 0);   chk("en_off_rgb", rgb, 0);
    chk("en_off_hsync", hs, 1); chk("en_off_vsync", vs, 1);
    chk("en_off_pix_x", px, 0); chk("en_off_pix_y", py, 0);
    chk("en_off_fs", fs, 0);
    repeat (3) @(negedge clk);
    en = 1'b1;
    wait_cnt(1'b0, 1);   chk("reen_fs_early", fs, 0);
    wait_cnt(1'b0, 2);   chk("reen_fs", fs, 1); chk("reen_hsync", hs, 0); chk("reen_vsync", vs, 0);
    wait_cnt(1'b0, 9);   chk("reen_hsync_low_end", hs, 0);
    wait_cnt(1'b0, 10);  chk("reen_hsync_high", hs, 1);
    wait_cnt(1'b0, 113); chk("reen_vsync_low_end", vs, 0);
    wait_cnt(1'b0, 114); chk("reen_vsync_high", vs, 1);

    // CLK_DIV=1 instance: asynchronous reset mid active line.
    rst1_n = 1'b1;
    wait_cnt(1'b1, 4 * 28 + 10 + 1);
    chk("d1_pre_de", de1, 1);
    chk("d1_pre_rgb", rgb1, 16'hABCD);
    #2;
    rst1_n = 1'b0;
    #1;
    chk("d1_async_de", de1, 0);     chk("d1_async_rgb", rgb1, 0);
    chk("d1_async_hsync", hs1, 1);  chk("d1_async_vsync", vs1, 1);
    chk("d1_async_pix_x", px1, 0);
    @(negedge clk);
    rst1_n = 1'b1;
    wait_cnt(1'b1, 1);   chk("d1_fs", fs1, 1); chk("d1_hsync0", hs1, 0); chk("d1_vsync0", vs1, 0);
    wait_cnt(1'b1, 2);   chk("d1_fs_end", fs1, 0);
    wait_cnt(1'b1, 4);   chk("d1_hsync_low_end", hs1, 0);
    wait_cnt(1'b1, 5);   chk("d1_hsync_high", hs1, 1);
    wait_cnt(1'b1, 29);  chk("d1_hsync_period", hs1, 0);
    wait_cnt(1'b1, 56);  chk("d1_vsync_low_end", vs1, 0);
    wait_cnt(1'b1, 57);  chk("d1_vsync_high", vs1, 1);
    wait_cnt(1'b1, 393); chk("d1_fs_next_frame", fs1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
